// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serialiser with valid/ready word input, one-word
// holding buffer for gapless streaming, selectable bit order and shift enable.
module piso_serializer #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             CLK,
   input  logic             RES,
   input  logic [WIDTH-1:0] IN_DATA,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic             SER_EN,
   output logic             SER_OUT,
   output logic             SER_VALID,
   output logic             LAST
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_sr;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_hb;
   logic             r_hb_full;

   state_t           w_state_n;
   logic [WIDTH-1:0] w_sr_n;
   logic [CW-1:0]    w_cnt_n;
   logic [WIDTH-1:0] w_hb_n;
   logic             w_hb_full_n;

   logic             w_accept;
   logic             w_xfer;
   logic             w_eow;
   logic [WIDTH-1:0] w_shifted;

   assign IN_READY  = !RES && !r_hb_full;
   assign SER_VALID = (r_state == S_SHIFT);
   assign LAST      = SER_VALID && (r_cnt == CNT_LAST);
   assign SER_OUT   = SER_VALID &&
                      (LSB_FIRST ? r_sr[0] : r_sr[WIDTH-1]);

   assign w_accept = IN_VALID && IN_READY;
   assign w_xfer   = SER_VALID && SER_EN;
   assign w_eow    = w_xfer && (r_cnt == CNT_LAST);

   generate
      if (LSB_FIRST) begin : g_lsb
         assign w_shifted = {1'b0, r_sr[WIDTH-1:1]};
      end else begin : g_msb
         assign w_shifted = {r_sr[WIDTH-2:0], 1'b0};
      end
   endgenerate

   always_comb begin
      w_state_n   = r_state;
      w_sr_n      = r_sr;
      w_cnt_n     = r_cnt;
      w_hb_n      = r_hb;
      w_hb_full_n = r_hb_full;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_sr_n    = IN_DATA;
               w_cnt_n   = '0;
               w_state_n = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_eow) begin
               w_cnt_n = '0;
               if (r_hb_full) begin
                  w_sr_n      = r_hb;
                  w_hb_full_n = 1'b0;
               end else if (w_accept) begin
                  w_sr_n = IN_DATA;
               end else begin
                  w_sr_n    = '0;
                  w_state_n = S_IDLE;
               end
            end else if (w_xfer) begin
               w_sr_n  = w_shifted;
               w_cnt_n = r_cnt + CW'(1);
            end
            // a full buffer forces IN_READY low, so only the bypass consumes here
            if (w_accept && !w_eow) begin
               w_hb_n      = IN_DATA;
               w_hb_full_n = 1'b1;
            end
         end
         default: begin
            w_state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RES) begin
         r_state   <= S_IDLE;
         r_sr      <= '0;
         r_cnt     <= '0;
         r_hb      <= '0;
         r_hb_full <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_sr      <= w_sr_n;
         r_cnt     <= w_cnt_n;
         r_hb      <= w_hb_n;
         r_hb_full <= w_hb_full_n;
      end
   end

endmodule
